dfi_upd_sched: RTL and testbench



---
 rtl/dfi_upd_sched.sv | 211 +++++++++++++++++++++
 tb/tb_dfi_upd_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dfi_upd_sched.sv
// Purpose: sequences DFI PHY init, periodic ctrlupd and PHY-requested phyupd around the command path.
// Latency: every output is registered; a response lands one cycle after the sampled input that triggers it.
// Backpressure: mc_stall_o blocks the command scheduler; handshakes wait on mc_idle_i and the PHY req/ack.
module dfi_upd_sched #(
    parameter int T_CTRLUPD_INTERVAL = 1024,
    parameter int T_CTRLUPD_MIN      = 4,
    parameter int T_CTRLUPD_MAX      = 32,
    parameter int T_PHYUPD_RESP      = 16,
    parameter int CNT_WIDTH          = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic mc_idle_i,
    input  logic dfi_init_complete_i,
    input  logic dfi_ctrlupd_ack_i,
    input  logic dfi_phyupd_req_i,
    input  logic dfi_phyupd_type_i,
    output logic dfi_init_start_o,
    output logic dfi_ctrlupd_req_o,
    output logic dfi_phyupd_ack_o,
    output logic mc_stall_o,
    output logic ready_o,
    output logic upd_type_o,
    output logic upd_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_RUN      = 3'd2,
        ST_CU_DRAIN = 3'd3,
        ST_CU_REQ   = 3'd4,
        ST_PU_DRAIN = 3'd5,
        ST_PU_ACK   = 3'd6
    } state_t;

    localparam logic [CNT_WIDTH-1:0] INT_LAST = CNT_WIDTH'(T_CTRLUPD_INTERVAL - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_MIN = CNT_WIDTH'(T_CTRLUPD_MIN);
    localparam logic [CNT_WIDTH-1:0] HOLD_MAX = CNT_WIDTH'(T_CTRLUPD_MAX);
    localparam logic [CNT_WIDTH-1:0] RESP_MAX = CNT_WIDTH'(T_PHYUPD_RESP);

    state_t               state_q, state_d;
    logic                 init_start_q, init_start_d;
    logic                 ctrlupd_req_q, ctrlupd_req_d;
    logic                 phyupd_ack_q, phyupd_ack_d;
    logic                 stall_q, stall_d;
    logic                 ready_q, ready_d;
    logic                 upd_type_q, upd_type_d;
    logic                 upd_err_q, upd_err_d;
    logic                 pend_q, pend_d;
    logic [CNT_WIDTH-1:0] int_cnt_q, int_cnt_d;
    logic [CNT_WIDTH-1:0] hold_q, hold_d;
    logic [CNT_WIDTH-1:0] resp_q, resp_d;

    logic int_hit;
    assign int_hit = (int_cnt_q >= INT_LAST);

    // Next-state and next-output decode; every register holds unless a transition says otherwise.
    always_comb begin
        state_d       = state_q;
        init_start_d  = init_start_q;
        ctrlupd_req_d = ctrlupd_req_q;
        phyupd_ack_d  = phyupd_ack_q;
        stall_d       = stall_q;
        ready_d       = ready_q;
        upd_type_d    = upd_type_q;
        upd_err_d     = upd_err_q;
        pend_d        = pend_q;
        int_cnt_d     = int_cnt_q;
        hold_d        = hold_q;
        resp_d        = resp_q;

        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d      = ST_INIT;
                    init_start_d = 1'b1;
                end
            end

            ST_INIT: begin
                if (dfi_init_complete_i) begin
                    state_d      = ST_RUN;
                    init_start_d = 1'b0;
                    ready_d      = 1'b1;
                    stall_d      = 1'b0;
                    int_cnt_d    = '0;
                end
            end

            ST_RUN: begin
                int_cnt_d = int_cnt_q + 1'b1;
                if (!dfi_init_complete_i) begin
                    // PHY lost init: stop traffic and re-run the init handshake.
                    state_d      = ST_INIT;
                    ready_d      = 1'b0;
                    stall_d      = 1'b1;
                    init_start_d = 1'b1;
                end else if (dfi_phyupd_req_i) begin
                    // A ctrlupd that falls due on the same cycle is remembered, not lost.
                    state_d    = ST_PU_DRAIN;
                    stall_d    = 1'b1;
                    upd_type_d = dfi_phyupd_type_i;
                    resp_d     = CNT_WIDTH'(1);
                    pend_d     = int_hit;
                end else if (int_hit) begin
                    state_d = ST_CU_DRAIN;
                    stall_d = 1'b1;
                end
            end

            ST_CU_DRAIN: begin
                if (dfi_phyupd_req_i) begin
                    state_d    = ST_PU_DRAIN;
                    upd_type_d = dfi_phyupd_type_i;
                    resp_d     = CNT_WIDTH'(1);
                    pend_d     = 1'b1;
                end else if (mc_idle_i) begin
                    state_d       = ST_CU_REQ;
                    ctrlupd_req_d = 1'b1;
                    hold_d        = CNT_WIDTH'(1);
                end
            end

            ST_CU_REQ: begin
                // hold_q is the number of cycles req has been high, including this one.
                hold_d = hold_q + 1'b1;
                if ((hold_q >= HOLD_MIN && !dfi_ctrlupd_ack_i) || hold_q >= HOLD_MAX) begin
                    if (dfi_ctrlupd_ack_i) begin
                        upd_err_d = 1'b1;
                    end
                    state_d       = ST_RUN;
                    ctrlupd_req_d = 1'b0;
                    stall_d       = 1'b0;
                    int_cnt_d     = '0;
                    pend_d        = 1'b0;
                    hold_d        = '0;
                end
            end

            ST_PU_DRAIN: begin
                if (resp_q < RESP_MAX) begin
                    resp_d = resp_q + 1'b1;
                end
                if (!dfi_phyupd_req_i) begin
                    // PHY withdrew before the grant.
                    state_d = pend_q ? ST_CU_DRAIN : ST_RUN;
                    stall_d = pend_q;
                end else if (mc_idle_i) begin
                    state_d      = ST_PU_ACK;
                    phyupd_ack_d = 1'b1;
                end else if (resp_q >= RESP_MAX) begin
                    upd_err_d = 1'b1;
                end
            end

            ST_PU_ACK: begin
                if (!dfi_phyupd_req_i) begin
                    state_d      = pend_q ? ST_CU_DRAIN : ST_RUN;
                    phyupd_ack_d = 1'b0;
                    stall_d      = pend_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            init_start_q  <= 1'b0;
            ctrlupd_req_q <= 1'b0;
            phyupd_ack_q  <= 1'b0;
            stall_q       <= 1'b1;
            ready_q       <= 1'b0;
            upd_type_q    <= 1'b0;
            upd_err_q     <= 1'b0;
            pend_q        <= 1'b0;
            int_cnt_q     <= '0;
            hold_q        <= '0;
            resp_q        <= '0;
        end else begin
            state_q       <= state_d;
            init_start_q  <= init_start_d;
            ctrlupd_req_q <= ctrlupd_req_d;
            phyupd_ack_q  <= phyupd_ack_d;
            stall_q       <= stall_d;
            ready_q       <= ready_d;
            upd_type_q    <= upd_type_d;
            upd_err_q     <= upd_err_d;
            pend_q        <= pend_d;
            int_cnt_q     <= int_cnt_d;
            hold_q        <= hold_d;
            resp_q        <= resp_d;
        end
    end

    assign dfi_init_start_o  = init_start_q;
    assign dfi_ctrlupd_req_o = ctrlupd_req_q;
    assign dfi_phyupd_ack_o  = phyupd_ack_q;
    assign mc_stall_o        = stall_q;
    assign ready_o           = ready_q;
    assign upd_type_o        = upd_type_q;
    assign upd_err_o         = upd_err_q;

endmodule

// File: tb/tb_dfi_upd_sched.sv
// Purpose: directed self-checking bench for dfi_upd_sched (init, ctrlupd, phyupd, timeout, reset).
// Latency: checks are taken 1 time unit after the rising edge, where registered outputs have settled.
// Backpressure: mc_idle and the PHY req/ack lines are driven per cycle from a linear script.
module tb_dfi_upd_sched;

    logic clk = 1'b0;
    logic rst_n, en, mc_idle, init_complete, ctrlupd_ack, phyupd_req, phyupd_type;
    logic init_start, ctrlupd_req, phyupd_ack, mc_stall, ready, upd_type, upd_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    dfi_upd_sched #(
        .T_CTRLUPD_INTERVAL(64),
        .T_CTRLUPD_MIN     (4),
        .T_CTRLUPD_MAX     (32),
        .T_PHYUPD_RESP     (16),
        .CNT_WIDTH         (16)
    ) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .en_i               (en),
        .mc_idle_i          (mc_idle),
        .dfi_init_complete_i(init_complete),
        .dfi_ctrlupd_ack_i  (ctrlupd_ack),
        .dfi_phyupd_req_i   (phyupd_req),
        .dfi_phyupd_type_i  (phyupd_type),
        .dfi_init_start_o   (init_start),
        .dfi_ctrlupd_req_o  (ctrlupd_req),
        .dfi_phyupd_ack_o   (phyupd_ack),
        .mc_stall_o         (mc_stall),
        .ready_o            (ready),
        .upd_type_o         (upd_type),
        .upd_err_o          (upd_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Handshake exclusivity and stall coverage, checked every cycle.
    always @(negedge clk) begin
        checks++;
        assert (!(ctrlupd_req === 1'b1 && phyupd_ack === 1'b1)) else begin
            failures++;
            $error("FAIL overlap at cycle %0d: req=%b ack=%b expected not both 1", cyc, ctrlupd_req, phyupd_ack);
        end
        if (ctrlupd_req === 1'b1 || phyupd_ack === 1'b1) begin
            checks++;
            assert (mc_stall === 1'b1) else begin
                failures++;
                $error("FAIL stall_cover at cycle %0d: got %b expected 1", cyc, mc_stall);
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; mc_idle = 1'b0; init_complete = 1'b0;
        ctrlupd_ack = 1'b0; phyupd_req = 1'b0; phyupd_type = 1'b0;
        repeat (3) step();

        // Reset values.
        chk("rst_init_start", init_start, 1'b0);
        chk("rst_ctrlupd_req", ctrlupd_req, 1'b0);
        chk("rst_phyupd_ack", phyupd_ack, 1'b0);
        chk("rst_stall", mc_stall, 1'b1);
        chk("rst_ready", ready, 1'b0);
        chk("rst_upd_type", upd_type, 1'b0);
        chk("rst_upd_err", upd_err, 1'b0);

        // Init handshake: en in cycle 2, complete in cycle 10.
        rst_n = 1'b1;
        cyc = 1;
        step();
        en = 1'b1;
        step();
        en = 1'b0;
        chk("init_start_c3", init_start, 1'b1);
        for (int c = 4; c <= 9; c++) begin
            step();
            chk("init_start_hold", init_start, 1'b1);
            chk("init_not_ready", ready, 1'b0);
        end
        step();
        chk("init_start_c10", init_start, 1'b1);
        init_complete = 1'b1;
        mc_idle = 1'b1;
        step();
        chk("init_done_start", init_start, 1'b0);
        chk("init_done_ready", ready, 1'b1);
        chk("init_done_stall", mc_stall, 1'b0);

        // Periodic ctrlupd: hit at 74, drain 75, req 76; ack 79..84 -> req low at 86.
        run_to(74);
        chk("cu1_pre_stall", mc_stall, 1'b0);
        chk("cu1_pre_req", ctrlupd_req, 1'b0);
        step();
        chk("cu1_drain_stall", mc_stall, 1'b1);
        chk("cu1_drain_req", ctrlupd_req, 1'b0);
        step();
        chk("cu1_req_rise", ctrlupd_req, 1'b1);
        run_to(79);
        ctrlupd_ack = 1'b1;
        run_to(85);
        ctrlupd_ack = 1'b0;
        chk("cu1_req_held", ctrlupd_req, 1'b1);
        step();
        chk("cu1_req_drop", ctrlupd_req, 1'b0);
        chk("cu1_stall_rel", mc_stall, 1'b0);
        chk("cu1_no_err", upd_err, 1'b0);

        // Declined ctrlupd 64 RUN cycles later: req 151..154.
        run_to(150);
        chk("cu2_drain_req", ctrlupd_req, 1'b0);
        chk("cu2_drain_stall", mc_stall, 1'b1);
        step();
        chk("cu2_req_rise", ctrlupd_req, 1'b1);
        run_to(154);
        chk("cu2_req_4th", ctrlupd_req, 1'b1);
        step();
        chk("cu2_req_drop", ctrlupd_req, 1'b0);
        chk("cu2_no_err", upd_err, 1'b0);

        // phyupd during CU_DRAIN: drain at 219, PU entry 220, ack 226..230, ctrlupd req at 232.
        run_to(218);
        mc_idle = 1'b0;
        step();
        phyupd_req = 1'b1;
        phyupd_type = 1'b1;
        step();
        phyupd_type = 1'b0;
        chk("pu1_type_latch", upd_type, 1'b1);
        chk("pu1_stall", mc_stall, 1'b1);
        chk("pu1_no_cureq", ctrlupd_req, 1'b0);
        run_to(225);
        mc_idle = 1'b1;
        chk("pu1_ack_wait", phyupd_ack, 1'b0);
        step();
        chk("pu1_ack_rise", phyupd_ack, 1'b1);
        run_to(230);
        phyupd_req = 1'b0;
        chk("pu1_ack_held", phyupd_ack, 1'b1);
        step();
        chk("pu1_ack_drop", phyupd_ack, 1'b0);
        chk("pu1_cureq_not_yet", ctrlupd_req, 1'b0);
        chk("pu1_stall_kept", mc_stall, 1'b1);
        step();
        chk("pu1_cureq_follow", ctrlupd_req, 1'b1);
        run_to(236);
        chk("pu1_cureq_done", ctrlupd_req, 1'b0);
        chk("pu1_no_err", upd_err, 1'b0);

        // phyupd timeout from RUN: entry 241, err at 257, ack at 262.
        run_to(240);
        phyupd_req = 1'b1;
        mc_idle = 1'b0;
        step();
        chk("pu2_type_latch", upd_type, 1'b0);
        run_to(256);
        chk("pu2_err_before", upd_err, 1'b0);
        step();
        chk("pu2_err_set", upd_err, 1'b1);
        run_to(261);
        mc_idle = 1'b1;
        chk("pu2_ack_wait", phyupd_ack, 1'b0);
        step();
        chk("pu2_ack_rise", phyupd_ack, 1'b1);
        step();
        phyupd_req = 1'b0;
        step();
        chk("pu2_ack_drop", phyupd_ack, 1'b0);
        chk("pu2_stall_rel", mc_stall, 1'b0);

        // Interval counter survives the phyupd: drain at 323, req at 324.
        run_to(322);
        chk("cu3_pre_stall", mc_stall, 1'b0);
        step();
        chk("cu3_drain_req", ctrlupd_req, 1'b0);
        step();
        chk("cu3_req_rise", ctrlupd_req, 1'b1);

        // Reset while ctrlupd req is high.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_req", ctrlupd_req, 1'b0);
        chk("rst2_ready", ready, 1'b0);
        chk("rst2_stall", mc_stall, 1'b1);
        chk("rst2_err", upd_err, 1'b0);
        run_to(330);
        chk("rst2_idle", init_start, 1'b0);
        en = 1'b1;
        step();
        en = 1'b0;
        chk("rst2_init_start", init_start, 1'b1);
        step();
        chk("rst2_ready_again", ready, 1'b1);
        chk("rst2_init_drop", init_start, 1'b0);

        // Ack held 40 cycles: req 397..428, err at 429.
        run_to(396);
        chk("cu4_drain_stall", mc_stall, 1'b1);
        step();
        ctrlupd_ack = 1'b1;
        chk("cu4_req_rise", ctrlupd_req, 1'b1);
        run_to(428);
        chk("cu4_req_32nd", ctrlupd_req, 1'b1);
        chk("cu4_err_before", upd_err, 1'b0);
        step();
        chk("cu4_req_drop", ctrlupd_req, 1'b0);
        chk("cu4_err_set", upd_err, 1'b1);
        chk("cu4_stall_rel", mc_stall, 1'b0);
        run_to(437);
        ctrlupd_ack = 1'b0;
        run_to(440);
        chk("cu4_err_sticky", upd_err, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
